pipe_ctrl: RTL and testbench

Parametrised pipeline control unit for the in-order RISC-V core. It owns the valid bits of every inter-stage buffer, the PC write enable, load-use interlock, ID-stage branch flush, and a req/ack handshake to a multi-cycle data memory. This handshake replaces the hard-wired zero global stall, so the core can sit behind slow or cached memory. It sits beside the stage buffers in the CPU top; the buffers take their enable and valid inputs from it.

---
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: stage valid bits, PC/stage enables, load-use interlock, branch flush, memory req/ack stall.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int STAGES = 4,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_load_i,
  input  logic              branch_taken_i,
  input  logic              mem_op_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              pc_write_o,
  output logic              pc_sel_o,
  output logic [STAGES-1:0] stage_en_o,
  output logic [STAGES-1:0] valid_o,
  output logic              run_o,
  output logic [CNT_W-1:0]  cyc_cnt_o,
  output logic [CNT_W-1:0]  ret_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int M = STAGES - 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [STAGES-1:0] valid_q, valid_d;
  logic              mem_stall;
  logic              load_use;
  logic              branch;
  logic              rs_match;

  always_comb begin
    run_o      = (state_q != IDLE);
    mem_req_o  = valid_q[M] & mem_op_i & run_o;
    mem_stall  = mem_req_o & ~mem_ack_i;
    rs_match   = (id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                 (id_use_rs2_i && (id_rs2_i == ex_rd_i));
    load_use   = run_o & ~mem_stall & valid_q[1] & valid_q[0] & ex_load_i &
                 (ex_rd_i != '0) & rs_match;
    branch     = run_o & ~mem_stall & ~load_use & branch_taken_i & valid_q[0];

    state_d    = state_q;
    pc_write_o = 1'b0;
    pc_sel_o   = 1'b0;
    stage_en_o = '1;
    valid_d    = '0;

    unique case (state_q)
      IDLE:     if (start_i)   state_d = RUN;
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ack_i) state_d = RUN;
      default:                 state_d = IDLE;
    endcase

    if (run_o) begin
      valid_d = {valid_q[STAGES-2:0], 1'b1};
      if (mem_stall) begin
        // Hold everything up to MEM; a bubble into MEM/WB prevents a second write-back.
        stage_en_o             = '0;
        stage_en_o[STAGES-1]   = 1'b1;
        valid_d                = {1'b0, valid_q[STAGES-2:0]};
      end else if (load_use) begin
        stage_en_o[0] = 1'b0;
        valid_d[0]    = valid_q[0];
        valid_d[1]    = 1'b0;
      end else if (branch) begin
        pc_write_o = 1'b1;
        pc_sel_o   = 1'b1;
        valid_d[0] = 1'b0;
      end else begin
        pc_write_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cyc_q, ret_q, stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cyc_q   <= '0;
      ret_q   <= '0;
      stall_q <= '0;
    end else if (run_o) begin
      cyc_q <= cyc_q + ONE;
      if (valid_q[STAGES-1])    ret_q   <= ret_q + ONE;
      if (mem_stall | load_use) stall_q <= stall_q + ONE;
    end
  end

  assign cyc_cnt_o   = cyc_q;
  assign ret_cnt_o   = ret_q;
  assign stall_cnt_o = stall_q;
`else
  assign cyc_cnt_o   = '0;
  assign ret_cnt_o   = '0;
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle expected control vectors flow through a scoreboard queue.
// Vector layout: {run, mem_req, pc_write, pc_sel, stage_en[3:0], valid[3:0]}.
module tb_pipe_ctrl;
  localparam int STAGES = 4;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic              id_use_rs1_i, id_use_rs2_i, ex_load_i;
  logic              branch_taken_i, mem_op_i, mem_ack_i;
  logic              mem_req_o, pc_write_o, pc_sel_o, run_o;
  logic [STAGES-1:0] stage_en_o, valid_o;
  logic [CNT_W-1:0]  cyc_cnt_o, ret_cnt_o, stall_cnt_o;

  logic [11:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(STAGES), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_rd_i(ex_rd_i), .ex_load_i(ex_load_i),
    .branch_taken_i(branch_taken_i), .mem_op_i(mem_op_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o),
    .stage_en_o(stage_en_o), .valid_o(valid_o), .run_o(run_o),
    .cyc_cnt_o(cyc_cnt_o), .ret_cnt_o(ret_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    start_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
    id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0; ex_load_i = 1'b0;
    branch_taken_i = 1'b0; mem_op_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  // Inputs are already driven (at negedge); push, sample 1 ns later, pop and compare, then advance.
  task automatic cycle(input string tag, input logic [11:0] exp);
    logic [11:0] e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, {20'd0, run_o, mem_req_o, pc_write_o, pc_sel_o, stage_en_o, valid_o}, {20'd0, e});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input int cyc, input int ret, input int stl);
    check({tag, "_cyc"},   cyc_cnt_o,   PERF ? 32'(cyc) : 32'd0);
    check({tag, "_ret"},   ret_cnt_o,   PERF ? 32'(ret) : 32'd0);
    check({tag, "_stall"}, stall_cnt_o, PERF ? 32'(stl) : 32'd0);
  endtask

  task automatic set_lu(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                        input logic [REG_AW-1:0] rs2, input logic u1, input logic u2);
    ex_load_i = 1'b1; ex_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
    id_use_rs1_i = u1; id_use_rs2_i = u2;
  endtask

  initial begin
    clr();
    rst_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    cycle("reset", 12'b0000_1111_0000);
    check_cnt("reset", 0, 0, 0);
    rst_i = 1'b1;

    clr(); start_i = 1'b1; cycle("idle_start", 12'b0000_1111_0000);
    clr(); cycle("run0",  12'b1010_1111_0000);
    clr(); cycle("ramp1", 12'b1010_1111_0001);
    clr(); cycle("ramp2", 12'b1010_1111_0011);
    clr(); cycle("ramp3", 12'b1010_1111_0111);
    clr(); cycle("full0", 12'b1010_1111_1111);
    clr(); cycle("full1", 12'b1010_1111_1111);

    // Load-use on rs1 with a concurrent taken branch: interlock wins.
    clr(); set_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); branch_taken_i = 1'b1;
    cycle("lu_rs1_vs_br", 12'b1000_1110_1111);
    clr(); branch_taken_i = 1'b1; cycle("branch", 12'b1011_1111_1101);
    clr(); cycle("post_br0", 12'b1010_1111_1010);
    clr(); cycle("post_br1", 12'b1010_1111_0101);
    clr(); cycle("post_br2", 12'b1010_1111_1011);
    clr(); cycle("post_br3", 12'b1010_1111_0111);
    clr(); set_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); cycle("lu_rd0", 12'b1010_1111_1111);
    clr(); set_lu(5'd7, 5'd3, 5'd7, 1'b0, 1'b1); cycle("lu_rs2", 12'b1000_1110_1111);
    clr(); cycle("post_lu0", 12'b1010_1111_1101);
    clr(); cycle("post_lu1", 12'b1010_1111_1011);
    clr(); cycle("post_lu2", 12'b1010_1111_0111);
    clr(); set_lu(5'd7, 5'd7, 5'd7, 1'b0, 1'b0); cycle("lu_nouse", 12'b1010_1111_1111);
    check_cnt("pre_mem", 18, 11, 2);

    // Memory access acked after 3 wait cycles.
    clr(); mem_op_i = 1'b1; cycle("mem_req", 12'b1100_1000_1111);
    clr(); mem_op_i = 1'b1; start_i = 1'b1; cycle("mem_wait1", 12'b1100_1000_0111);
    clr(); mem_op_i = 1'b1; cycle("mem_wait2", 12'b1100_1000_0111);
    clr(); mem_op_i = 1'b1; mem_ack_i = 1'b1; cycle("mem_ack", 12'b1110_1111_0111);
    check_cnt("post_mem", 22, 12, 5);
    clr(); cycle("post_mem0", 12'b1010_1111_1111);
    clr(); mem_op_i = 1'b1; mem_ack_i = 1'b1; cycle("mem_ack_same", 12'b1110_1111_1111);
    clr(); mem_ack_i = 1'b1; cycle("ack_no_req", 12'b1010_1111_1111);

    // Mem stall outranks load-use and branch; then reset while waiting.
    clr(); mem_op_i = 1'b1; set_lu(5'd4, 5'd4, 5'd4, 1'b1, 1'b1); branch_taken_i = 1'b1;
    cycle("mem_vs_lu_br", 12'b1100_1000_1111);
    clr(); mem_op_i = 1'b1; rst_i = 1'b0; cycle("rst_in_wait", 12'b1100_1000_0111);
    check_cnt("after_rst", 0, 0, 0);
    clr(); rst_i = 1'b1; mem_op_i = 1'b1; cycle("idle_after_rst", 12'b0000_1111_0000);
    clr(); cycle("idle_hold", 12'b0000_1111_0000);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
